// File: rtl/int_ctrl.sv
// Interrupt controller: device and interval-timer requests, masked onto ext_int[5:0],
// with a small memory-mapped register block for mask, edge mode, timer and pending status.
module int_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  irq_src,
    input  logic        re,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [5:0]  ext_int
);

    logic [5:0]       irq_s_q, irq_s_d;
    logic [5:0]       irq_d_q, irq_d_d;
    logic [5:0]       edge_pend_q, edge_pend_d;
    logic [5:0]       mask_q, mask_d;
    logic [5:0]       edge_q, edge_d;
    logic [CNT_W-1:0] tcmp_q, tcmp_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             tctl_q, tctl_d;
    logic             tflag_q, tflag_d;
    logic [5:0]       ext_int_q, ext_int_d;
    logic [31:0]      rdata_q, rdata_d;

    logic       wr_pend, wr_mask, wr_edge, wr_tcmp, wr_tcnt, wr_tctl;
    logic [5:0] rise, w1c, edge_chg, pend;
    logic       match;

    always_comb begin
        wr_pend = we && (addr == 3'd0);
        wr_mask = we && (addr == 3'd1);
        wr_edge = we && (addr == 3'd2);
        wr_tcmp = we && (addr == 3'd3);
        wr_tcnt = we && (addr == 3'd4);
        wr_tctl = we && (addr == 3'd5);

        rise     = irq_s_q & ~irq_d_q;
        w1c      = wr_pend ? wdata[5:0] : '0;
        edge_chg = wr_edge ? (wdata[5:0] ^ edge_q) : '0;

        pend    = (edge_q & edge_pend_q) | (~edge_q & irq_s_q);
        pend[5] = pend[5] | tflag_q;

        match = tctl_q && (tcnt_q == tcmp_q) && (tcmp_q != '0);

        irq_s_d = irq_src;
        irq_d_d = irq_s_q;

        // A mode change discards any latched edge; otherwise a new edge beats a same-cycle W1C.
        edge_pend_d = ~edge_chg & ((edge_q & rise) | (edge_pend_q & ~w1c));

        mask_d = wr_mask ? wdata[5:0] : mask_q;
        edge_d = wr_edge ? wdata[5:0] : edge_q;
        tcmp_d = wr_tcmp ? wdata[CNT_W-1:0] : tcmp_q;
        tctl_d = wr_tctl ? wdata[0] : tctl_q;

        if (wr_tcnt) begin
            tcnt_d = wdata[CNT_W-1:0];
        end else if (match) begin
            tcnt_d = '0;
        end else if (tctl_q) begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end else begin
            tcnt_d = tcnt_q;
        end

        // A software load of TCNT suppresses the flag from a coincident match.
        if (match && !wr_tcnt) begin
            tflag_d = 1'b1;
        end else if (w1c[5]) begin
            tflag_d = 1'b0;
        end else begin
            tflag_d = tflag_q;
        end

        ext_int_d = pend & mask_q;

        rdata_d = rdata_q;
        if (re) begin
            rdata_d = '0;
            unique case (addr)
                3'd0: rdata_d[5:0]       = pend;
                3'd1: rdata_d[5:0]       = mask_q;
                3'd2: rdata_d[5:0]       = edge_q;
                3'd3: rdata_d[CNT_W-1:0] = tcmp_q;
                3'd4: rdata_d[CNT_W-1:0] = tcnt_q;
                3'd5: rdata_d[0]         = tctl_q;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_s_q     <= '0;
            irq_d_q     <= '0;
            edge_pend_q <= '0;
            mask_q      <= '0;
            edge_q      <= '0;
            tcmp_q      <= '0;
            tcnt_q      <= '0;
            tctl_q      <= 1'b0;
            tflag_q     <= 1'b0;
            ext_int_q   <= '0;
            rdata_q     <= '0;
        end else begin
            irq_s_q     <= irq_s_d;
            irq_d_q     <= irq_d_d;
            edge_pend_q <= edge_pend_d;
            mask_q      <= mask_d;
            edge_q      <= edge_d;
            tcmp_q      <= tcmp_d;
            tcnt_q      <= tcnt_d;
            tctl_q      <= tctl_d;
            tflag_q     <= tflag_d;
            ext_int_q   <= ext_int_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign ext_int = ext_int_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus random traffic, checked every cycle
// against a rule-level reference model through an expectation queue.
module tb_int_ctrl;

    localparam int unsigned CW    = 8;
    localparam logic [31:0] CMASK = 32'h0000_00FF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  irq_src = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [5:0]  ext_int;

    int total = 0;
    int bad   = 0;

    int_ctrl #(.CNT_W(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_src(irq_src),
        .re     (re),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ext_int(ext_int)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [5:0]  ext;
        logic [31:0] rd;
    } exp_t;
    exp_t exp_q[$];

    // Reference state: the architectural registers and the two sync stages.
    logic [5:0]  m_mask = '0, m_edge = '0, m_s = '0, m_d = '0, m_ep = '0, m_ext = '0;
    logic [31:0] m_tcmp = '0, m_tcnt = '0, m_rd = '0;
    logic        m_tctl = 1'b0, m_tflag = 1'b0;

    function automatic logic [5:0] pend_now();
        logic [5:0] p;
        for (int i = 0; i < 6; i++) p[i] = m_edge[i] ? m_ep[i] : m_s[i];
        p[5] = p[5] | m_tflag;
        return p;
    endfunction

    task automatic model_step();
        logic [5:0]  p;
        logic [5:0]  n_ep;
        logic [31:0] n_cnt;
        logic        hit, tcnt_wr, n_tf;
        if (rst) begin
            m_mask = '0; m_edge = '0; m_s = '0; m_d = '0; m_ep = '0; m_ext = '0;
            m_tcmp = '0; m_tcnt = '0; m_rd = '0; m_tctl = 1'b0; m_tflag = 1'b0;
            return;
        end
        p = pend_now();
        if (re) begin
            case (addr)
                3'd0: m_rd = {26'd0, p};
                3'd1: m_rd = {26'd0, m_mask};
                3'd2: m_rd = {26'd0, m_edge};
                3'd3: m_rd = m_tcmp;
                3'd4: m_rd = m_tcnt;
                3'd5: m_rd = {31'd0, m_tctl};
                default: m_rd = 32'd0;
            endcase
        end
        m_ext = p & m_mask;

        hit     = m_tctl && (m_tcnt == m_tcmp) && (m_tcmp != 0);
        tcnt_wr = we && (addr == 3'd4);
        if (tcnt_wr)     n_cnt = wdata & CMASK;
        else if (hit)    n_cnt = 0;
        else if (m_tctl) n_cnt = (m_tcnt + 1) & CMASK;
        else             n_cnt = m_tcnt;

        n_tf = m_tflag;
        if (hit && !tcnt_wr) n_tf = 1'b1;
        else if (we && addr == 3'd0 && wdata[5]) n_tf = 1'b0;

        for (int i = 0; i < 6; i++) begin
            n_ep[i] = m_ep[i];
            if (we && addr == 3'd2 && wdata[i] != m_edge[i]) n_ep[i] = 1'b0;
            else if (m_edge[i] && m_s[i] && !m_d[i])          n_ep[i] = 1'b1;
            else if (we && addr == 3'd0 && wdata[i])          n_ep[i] = 1'b0;
        end

        if (we) begin
            case (addr)
                3'd1: m_mask = wdata[5:0];
                3'd2: m_edge = wdata[5:0];
                3'd3: m_tcmp = wdata & CMASK;
                3'd5: m_tctl = wdata[0];
                default: ;
            endcase
        end
        m_d     = m_s;
        m_s     = irq_src;
        m_ep    = n_ep;
        m_tcnt  = n_cnt;
        m_tflag = n_tf;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        exp_q.push_back('{ext: m_ext, rd: m_rd});
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: no expectation queued at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            total++;
            if (ext_int !== e.ext) begin
                bad++;
                $display("FAIL ext_int at %0t: got %02h expected %02h", $time, ext_int, e.ext);
            end
            total++;
            if (rdata !== e.rd) begin
                bad++;
                $display("FAIL rdata at %0t: got %08h expected %08h", $time, rdata, e.rd);
            end
        end
    end

    task automatic tick(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        we = w; re = r; addr = a; wdata = d;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0, 32'd0);
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        tick(1'b1, 1'b0, a, d);
    endtask
    task automatic rd(input logic [2:0] a);
        tick(1'b0, 1'b1, a, 32'd0);
    endtask
    task automatic rd_all();
        for (int i = 0; i < 8; i++) rd(3'(i));
    endtask

    initial begin
        idle(2);
        rst = 1'b0;
        rd_all();

        // level-mode pulse on line 2
        wr(3'd1, 32'h3F); wr(3'd2, 32'h00);
        irq_src = 6'h04; idle(4);
        irq_src = 6'h00; idle(4);

        // edge mode on line 0, W1C, and a new edge coincident with the clear
        wr(3'd2, 32'h01); wr(3'd1, 32'h01);
        irq_src = 6'h01; idle(1); irq_src = 6'h00; idle(3);
        rd(3'd0); wr(3'd0, 32'h01); idle(2);
        irq_src = 6'h01; idle(1); irq_src = 6'h00;
        wr(3'd0, 32'h01); idle(3); rd(3'd0);

        // masked edge on line 3, then unmask
        wr(3'd1, 32'h00); wr(3'd2, 32'h08);
        irq_src = 6'h08; idle(1); irq_src = 6'h00; idle(3);
        rd(3'd0); wr(3'd1, 32'h08); idle(2); wr(3'd0, 32'h08); idle(2);

        // periodic timer, W1C of the timer flag
        wr(3'd1, 32'h20); wr(3'd3, 32'd4); wr(3'd4, 32'd0); wr(3'd5, 32'd1);
        idle(12); wr(3'd0, 32'h20); idle(7); rd(3'd4); rd(3'd0);

        // TCNT load in the cycle it would match
        for (int i = 0; i < 20; i++) begin
            if (m_tcnt == 32'd3) break;
            idle(1);
        end
        wr(3'd4, 32'd4); rd(3'd4); rd(3'd4); rd(3'd4); rd(3'd0);

        // natural rollover with no compare, and read/write to the same address
        wr(3'd5, 32'd0); wr(3'd3, 32'd0); wr(3'd4, 32'hFD); wr(3'd5, 32'd1);
        for (int i = 0; i < 5; i++) rd(3'd4);
        rd(3'd0);
        tick(1'b1, 1'b1, 3'd1, 32'h2A); rd(3'd1);

        // mid-operation reset with ext_int = 0x21
        wr(3'd0, 32'h3F); wr(3'd3, 32'd3); wr(3'd4, 32'd0);
        wr(3'd1, 32'h21); wr(3'd2, 32'h01); wr(3'd5, 32'd1);
        irq_src = 6'h01; idle(1); irq_src = 6'h00; idle(6);
        rst = 1'b1; idle(1); rst = 1'b0;
        rd_all(); idle(3); rd(3'd4);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  a;
            logic [31:0] d;
            irq_src = 6'($urandom);
            rst     = ($urandom_range(0, 99) == 0);
            a       = 3'($urandom_range(0, 7));
            d       = $urandom;
            if (a == 3'd3 || a == 3'd4) d = $urandom_range(0, 12);
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), a, d);
        end
        rst = 1'b0; irq_src = '0;
        idle(3);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
